vdp_vram_arbiter: RTL and testbench

Owns the TMS9918-style VDP CPU interface: control port (0xBF) and data port (0xBE) decoding, the VDP register file, the 14-bit auto-incrementing VRAM address, the read-ahead buffer and the status register. Arbitrates the single VRAM port between the display fetch engine and the CPU data port. Sits between the CPU I/O decode in the top level and the video/VRAM datapath.

---
 rtl/vdp_vram_arbiter.sv | 159 +++++++++++++++
 tb/tb_vdp_vram_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_vram_arbiter.sv
// TMS9918-style VDP CPU port and VRAM arbiter: register file, auto-increment address, read-ahead, status.
// Optional VDP_STARVE_GUARD_EN: bounds how long a CPU access may wait behind display fetches.
module vdp_vram_arbiter #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_ce,
  input  logic              port_wr,
  input  logic              port_rd,
  input  logic              port_sel,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_valid,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [7:0]        vram_wdata,
  input  logic [7:0]        vram_rdata,
  output logic [63:0]       regs,
  input  logic              int_set,
  input  logic              coll_set,
  input  logic              fifth_set,
  input  logic [4:0]        fifth_num,
  output logic              int_n,
  output logic              cpu_busy
);
  typedef enum logic [1:0] {IDLE, PEND, ISSUE, CAPT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        latch;
  logic [7:0]        buffer;
  logic [7:0]        op_data;
  logic              second;
  logic              rd_q;
  logic              op_we;
  logic              held;
  logic              flag_f;
  logic              flag_5s;
  logic              flag_c;
  logic [4:0]        fifth_q;

  logic wr_ev, rd_ev, ctl_wr, data_wr, data_rd, stat_rd;
  logic ctl_second, reg_wr, addr_wr, prefetch, new_op, cpu_go;
  logic f_nxt, r1_ie_nxt;

  // Port event decode; a read counts only on the cpu_ce sample where port_rd rises.
  always_comb begin
    wr_ev      = cpu_ce & port_wr;
    rd_ev      = cpu_ce & port_rd & ~rd_q;
    ctl_wr     = wr_ev & port_sel;
    data_wr    = wr_ev & ~port_sel;
    data_rd    = rd_ev & ~port_sel;
    stat_rd    = rd_ev & port_sel;
    ctl_second = ctl_wr & second;
    reg_wr     = ctl_second & cpu_din[7] & (cpu_din[5:3] == 3'd0);
    addr_wr    = ctl_second & ~cpu_din[7];
    prefetch   = addr_wr & ~cpu_din[6];
    new_op     = data_wr | data_rd | prefetch;
    f_nxt      = int_set | (flag_f & ~stat_rd);
    r1_ie_nxt  = (reg_wr && (cpu_din[2:0] == 3'd1)) ? latch[5] : regs[13];
  end

`ifdef VDP_STARVE_GUARD_EN
  localparam int unsigned AGE_W = 8;
  logic [AGE_W-1:0] age;

  // Counts cycles spent waiting in PEND; forces the CPU slot once the limit is hit.
  always_ff @(posedge clk) begin
    if (!reset_n)           age <= '0;
    else if (state == PEND) age <= age + AGE_W'(1);
    else                    age <= '0;
  end

  assign cpu_go = ~disp_req | ((32'(age) + 32'd1) >= STARVE_MAX);
`else
  assign cpu_go = ~disp_req;
`endif

  assign disp_gnt   = disp_req & (state != ISSUE);
  assign vram_addr  = (state == ISSUE) ? addr : disp_addr;
  assign vram_we    = (state == ISSUE) & op_we;
  assign vram_wdata = op_data;
  assign cpu_busy   = (state != IDLE);
  assign cpu_dout   = port_sel ? {flag_f, flag_5s, flag_c, fifth_q} : buffer;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr       <= '0;
      latch      <= '0;
      buffer     <= '0;
      op_data    <= '0;
      second     <= 1'b0;
      rd_q       <= 1'b0;
      op_we      <= 1'b0;
      held       <= 1'b0;
      flag_f     <= 1'b0;
      flag_5s    <= 1'b0;
      flag_c     <= 1'b0;
      fifth_q    <= '0;
      regs       <= '0;
      int_n      <= 1'b1;
      disp_valid <= 1'b0;
    end else begin
      disp_valid <= disp_gnt;
      if (cpu_ce) rd_q <= port_rd;

      if (ctl_wr) begin
        if (!second) latch <= cpu_din;
        second <= ~second;
      end
      if (data_wr | data_rd | stat_rd) second <= 1'b0;

      if (reg_wr) regs[{cpu_din[2:0], 3'b000} +: 8] <= latch;

      // Latest access overwrites the held op; an op already on the port uses the old copy.
      if (new_op) begin
        op_we   <= data_wr;
        op_data <= cpu_din;
      end

      if (data_wr)            buffer <= cpu_din;
      else if (state == CAPT) buffer <= vram_rdata;

      if (addr_wr)             addr <= ADDR_W'({cpu_din[5:0], latch});
      else if (state == ISSUE) addr <= addr + ADDR_W'(1);

      case (state)
        IDLE:  if (new_op) state <= PEND;
        PEND:  if (cpu_go) state <= ISSUE;
        ISSUE: begin
          if (op_we) begin
            state <= new_op ? PEND : IDLE;
            held  <= 1'b0;
          end else begin
            state <= CAPT;
            held  <= new_op;
          end
        end
        CAPT: begin
          state <= (held | new_op) ? PEND : IDLE;
          held  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      flag_f  <= f_nxt;
      flag_5s <= fifth_set | (flag_5s & ~stat_rd);
      flag_c  <= coll_set | (flag_c & ~stat_rd);
      if (fifth_set) fifth_q <= fifth_num;
      int_n   <= ~(f_nxt & r1_ie_nxt);
    end
  end
endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Directed bench for vdp_vram_arbiter with a 16K x 8 synchronous VRAM model.
module tb_vdp_vram_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_ce, port_wr, port_rd, port_sel;
  logic [7:0]  cpu_din, cpu_dout;
  logic        disp_req;
  logic [13:0] disp_addr;
  logic        disp_gnt, disp_valid;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata, vram_rdata;
  logic [63:0] regs;
  logic        int_set, coll_set, fifth_set;
  logic [4:0]  fifth_num;
  logic        int_n, cpu_busy;

  logic [7:0]  mem [16384] = '{default: 8'h00};
  logic        pre_we = 1'b0;
  logic [13:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;
  int          wr_cnt = 0;
  logic [13:0] last_wa = '0;
  logic [7:0]  last_wd = '0;

  int vectors = 0;
  int miscompares = 0;

  vdp_vram_arbiter #(.ADDR_W(14), .STARVE_MAX(3)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_ce(cpu_ce), .port_wr(port_wr), .port_rd(port_rd),
    .port_sel(port_sel), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .disp_req(disp_req),
    .disp_addr(disp_addr), .disp_gnt(disp_gnt), .disp_valid(disp_valid), .vram_addr(vram_addr),
    .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .regs(regs),
    .int_set(int_set), .coll_set(coll_set), .fifth_set(fifth_set), .fifth_num(fifth_num),
    .int_n(int_n), .cpu_busy(cpu_busy)
  );

  always #5 clk = ~clk;

  // VRAM model with a backdoor preload port and a write monitor.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (vram_we) begin
      mem[vram_addr] <= vram_wdata;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= vram_addr;
      last_wd <= vram_wdata;
    end
    vram_rdata <= mem[vram_addr];
  end

  task automatic preload(input logic [13:0] a, input logic [7:0] d);
    @(negedge clk); pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk); pre_we = 1'b0;
  endtask

  task automatic cpu_write(input logic sel, input logic [7:0] d);
    @(negedge clk); port_sel = sel; cpu_din = d; port_wr = 1'b1; cpu_ce = 1'b1;
    @(negedge clk); port_wr = 1'b0; cpu_ce = 1'b0;
  endtask

  task automatic cpu_read(input logic sel, output logic [7:0] d);
    @(negedge clk); port_sel = sel; port_rd = 1'b1; cpu_ce = 1'b1;
    #1 d = cpu_dout;
    @(negedge clk); port_rd = 1'b0;
    @(negedge clk); cpu_ce = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while (cpu_busy && n < 50) begin @(negedge clk); n++; end
    ok = !cpu_busy;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; cpu_ce = 0; port_wr = 0; port_rd = 0; port_sel = 1; cpu_din = 0;
    disp_req = 0; disp_addr = 0; int_set = 0; coll_set = 0; fifth_set = 0; fifth_num = 0;
    repeat (3) @(negedge clk);
    vectors++; if (regs !== 64'h0) begin miscompares++; $display("FAIL reset_regs: got %h expected 0", regs); end
    vectors++; if (int_n !== 1'b1) begin miscompares++; $display("FAIL reset_int_n: got %b expected 1", int_n); end
    vectors++; if ({vram_we, disp_gnt, disp_valid, cpu_busy} !== 4'b0000) begin miscompares++;
      $display("FAIL reset_ctl: got %b expected 0000", {vram_we, disp_gnt, disp_valid, cpu_busy}); end
    vectors++; if (cpu_dout !== 8'h00) begin miscompares++; $display("FAIL reset_status: got %h expected 00", cpu_dout); end
    port_sel = 0; #1;
    vectors++; if (cpu_dout !== 8'h00) begin miscompares++; $display("FAIL reset_buffer: got %h expected 00", cpu_dout); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_data_write;
    bit ok; logic [7:0] d;
    cpu_write(1, 8'h00); cpu_write(1, 8'h40);
    cpu_write(0, 8'hAA);
    vectors++; if (cpu_busy !== 1'b1 || vram_we !== 1'b0) begin miscompares++;
      $display("FAIL wr_pend: got busy=%b we=%b expected busy=1 we=0", cpu_busy, vram_we); end
    @(negedge clk);
    vectors++; if ({vram_we, vram_addr, vram_wdata} !== {1'b1, 14'h0000, 8'hAA}) begin miscompares++;
      $display("FAIL wr_issue: got we=%b a=%h d=%h expected we=1 a=0000 d=aa", vram_we, vram_addr, vram_wdata); end
    wait_idle(ok);
    cpu_write(0, 8'hBB); wait_idle(ok);
    cpu_write(0, 8'hCC); wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wr_idle: got busy expected idle"); end
    vectors++; if (mem[0] !== 8'hAA || mem[1] !== 8'hBB) begin miscompares++;
      $display("FAIL wr_mem: got %h %h expected aa bb", mem[0], mem[1]); end
    vectors++; if (last_wa !== 14'h0002 || last_wd !== 8'hCC) begin miscompares++;
      $display("FAIL wr_addr_inc: got a=%h d=%h expected a=0002 d=cc", last_wa, last_wd); end
    cpu_read(0, d);
    vectors++; if (d !== 8'hCC) begin miscompares++; $display("FAIL wr_buffer: got %h expected cc", d); end
    wait_idle(ok);
  endtask

  task automatic test_regs;
    cpu_write(1, 8'hE2); cpu_write(1, 8'h81);
    vectors++; if (regs[15:8] !== 8'hE2) begin miscompares++; $display("FAIL reg_r1: got %h expected e2", regs[15:8]); end
    cpu_write(1, 8'h55); cpu_write(1, 8'h88);
    @(negedge clk);
    vectors++; if (regs !== 64'h0000_0000_0000_E200) begin miscompares++;
      $display("FAIL reg_ignored: got %h expected 000000000000e200", regs); end
  endtask

  task automatic test_read;
    bit ok; logic [7:0] d;
    preload(14'h1234, 8'h5A); preload(14'h1235, 8'h77);
    cpu_write(1, 8'h34); cpu_write(1, 8'h12);
    port_sel = 0;
    repeat (2) @(negedge clk);
    vectors++; if (cpu_dout !== 8'h00) begin miscompares++; $display("FAIL rd_early: got %h expected 00", cpu_dout); end
    @(negedge clk);
    vectors++; if (cpu_dout !== 8'h5A) begin miscompares++; $display("FAIL rd_latency: got %h expected 5a", cpu_dout); end
    @(negedge clk);
    cpu_read(0, d);
    vectors++; if (d !== 8'h5A) begin miscompares++; $display("FAIL rd_first: got %h expected 5a", d); end
    wait_idle(ok);
    cpu_read(0, d);
    vectors++; if (d !== 8'h77) begin miscompares++; $display("FAIL rd_next: got %h expected 77", d); end
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rd_idle: got busy expected idle"); end
  endtask

  task automatic test_status;
    logic [7:0] d;
    @(negedge clk); int_set = 1;
    @(negedge clk); int_set = 0;
    vectors++; if (int_n !== 1'b0) begin miscompares++; $display("FAIL int_low: got %b expected 0", int_n); end
    cpu_read(1, d);
    vectors++; if (d !== 8'h80) begin miscompares++; $display("FAIL stat_f: got %h expected 80", d); end
    vectors++; if (int_n !== 1'b1) begin miscompares++; $display("FAIL int_clear: got %b expected 1", int_n); end
    @(negedge clk); port_sel = 1; port_rd = 1; cpu_ce = 1; int_set = 1;
    #1 d = cpu_dout;
    @(negedge clk); port_rd = 0; int_set = 0;
    @(negedge clk); cpu_ce = 0;
    vectors++; if (d !== 8'h00 || int_n !== 1'b0) begin miscompares++;
      $display("FAIL stat_set_wins: got d=%h int_n=%b expected d=00 int_n=0", d, int_n); end
    cpu_read(1, d);
    vectors++; if (d !== 8'h80) begin miscompares++; $display("FAIL stat_f_kept: got %h expected 80", d); end
    @(negedge clk); fifth_set = 1; fifth_num = 5'h15; coll_set = 1;
    @(negedge clk); fifth_set = 0; fifth_num = 0; coll_set = 0;
    cpu_read(1, d);
    vectors++; if (d !== 8'h75) begin miscompares++; $display("FAIL stat_5s_c: got %h expected 75", d); end
    cpu_read(1, d);
    vectors++; if (d !== 8'h15 || int_n !== 1'b1) begin miscompares++;
      $display("FAIL stat_cleared: got d=%h int_n=%b expected d=15 int_n=1", d, int_n); end
  endtask

  task automatic test_starve;
    bit ok; int n;
    cpu_write(1, 8'h00); cpu_write(1, 8'h41);
    disp_addr = 14'h0200; disp_req = 1;
    cpu_write(0, 8'h3C);
    vectors++; if (disp_gnt !== 1'b1 || disp_valid !== 1'b1) begin miscompares++;
      $display("FAIL starve_disp: got gnt=%b valid=%b expected 1 1", disp_gnt, disp_valid); end
`ifdef VDP_STARVE_GUARD_EN
    n = 0;
    while (!vram_we && n < 20) begin @(negedge clk); n++; end
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL starve_wait: got %0d cycles expected 3", n); end
    vectors++; if (disp_gnt !== 1'b0) begin miscompares++; $display("FAIL starve_gnt: got %b expected 0", disp_gnt); end
`else
    n = 0;
    repeat (10) begin @(negedge clk); if (vram_we) n++; end
    vectors++; if (n !== 0) begin miscompares++; $display("FAIL strict_prio: got %0d write cycles expected 0", n); end
    disp_req = 0;
    @(negedge clk);
    vectors++; if (vram_we !== 1'b1) begin miscompares++; $display("FAIL strict_release: got %b expected 1", vram_we); end
`endif
    disp_req = 0;
    wait_idle(ok);
    vectors++; if (mem[14'h0100] !== 8'h3C) begin miscompares++; $display("FAIL starve_mem: got %h expected 3c", mem[14'h0100]); end
  endtask

  task automatic test_back_to_back;
    bit ok; int wc;
    cpu_write(1, 8'h00); cpu_write(1, 8'h42);
    wc = wr_cnt; disp_req = 1;
    cpu_write(0, 8'h01); cpu_write(0, 8'h02);
    disp_req = 0;
    wait_idle(ok);
    vectors++; if (wr_cnt - wc !== 1 || last_wd !== 8'h02 || mem[14'h0200] !== 8'h02) begin miscompares++;
      $display("FAIL b2b_last_wins: got writes=%0d d=%h mem=%h expected 1 02 02", wr_cnt - wc, last_wd, mem[14'h0200]); end
  endtask

  task automatic test_wrap;
    bit ok;
    cpu_write(1, 8'hFF); cpu_write(1, 8'h7F);
    cpu_write(0, 8'h11); wait_idle(ok);
    cpu_write(0, 8'h22); wait_idle(ok);
    vectors++; if (mem[14'h3FFF] !== 8'h11) begin miscompares++; $display("FAIL wrap_top: got %h expected 11", mem[14'h3FFF]); end
    vectors++; if (last_wa !== 14'h0000 || mem[0] !== 8'h22) begin miscompares++;
      $display("FAIL wrap_zero: got a=%h mem=%h expected 0000 22", last_wa, mem[0]); end
  endtask

  task automatic test_reset_pend;
    int wc;
    wc = wr_cnt; disp_req = 1;
    cpu_write(0, 8'h99);
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1; disp_req = 0;
    repeat (8) @(negedge clk);
    vectors++; if (wr_cnt !== wc || cpu_busy !== 1'b0) begin miscompares++;
      $display("FAIL reset_pend: got writes=%0d busy=%b expected 0 0", wr_cnt - wc, cpu_busy); end
    vectors++; if (regs !== 64'h0 || int_n !== 1'b1) begin miscompares++;
      $display("FAIL reset_pend_regs: got regs=%h int_n=%b expected 0 1", regs, int_n); end
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_regs();
    test_read();
    test_status();
    test_starve();
    test_back_to_back();
    test_wrap();
    test_reset_pend();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
